// File: rtl/sync_arith_result_collector.sv
// Buffers ALU result/status pairs in a FWFT FIFO and keeps flag/drop statistics.
// Latency: entry pushed at edge N is presented on o_data after edge N (no bypass).
// Backpressure: consumer stalls via i_ready; pushes into a full FIFO without a pop are dropped and counted.
module sync_arith_result_collector #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic [BITS-1:0]            i_result,
  input  logic [3:0]                 i_status,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [BITS-1:0]            o_data,
  output logic [3:0]                 o_data_status,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  input  logic                       i_clr,
  input  logic [1:0]                 i_cnt_sel,
  output logic [CNT_W-1:0]           o_flag_cnt,
  output logic [CNT_W-1:0]           o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [BITS-1:0]  mem_result [DEPTH];
  logic [3:0]       mem_status [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] flag_cnt [4];
  logic [CNT_W-1:0] drop_cnt;

  logic push;
  logic pop;
  logic drop;

  assign o_empty = (count == '0);
  assign o_full  = (count == FULL_LVL);
  assign o_valid = !o_empty;
  assign o_count = count;

  assign pop  = o_valid && i_ready;
  assign push = i_valid && (!o_full || pop);
  assign drop = i_valid && o_full && !pop;

  // Head is read straight from storage; zeroed while empty so stale entries never leak.
  assign o_data        = o_empty ? '0 : mem_result[rd_ptr];
  assign o_data_status = o_empty ? '0 : mem_status[rd_ptr];

  assign o_flag_cnt = flag_cnt[i_cnt_sel];
  assign o_drop_cnt = drop_cnt;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_result[wr_ptr] <= i_result;
      mem_status[wr_ptr] <= i_status;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Counters saturate; clear takes priority over any same-cycle increment.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) flag_cnt[i] <= '0;
      drop_cnt <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < 4; i++) flag_cnt[i] <= '0;
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push && i_status[i] && (flag_cnt[i] != '1))
          flag_cnt[i] <= flag_cnt[i] + 1'b1;
      end
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_arith_result_collector.sv
// Randomized and directed bench for sync_arith_result_collector against a queue-based reference model.
module tb_sync_arith_result_collector;

  localparam int BITS  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_valid;
  logic [BITS-1:0]  i_result;
  logic [3:0]       i_status;
  logic             o_valid;
  logic             i_ready;
  logic [BITS-1:0]  o_data;
  logic [3:0]       o_data_status;
  logic             o_full;
  logic             o_empty;
  logic [CW-1:0]    o_count;
  logic             i_clr;
  logic [1:0]       i_cnt_sel;
  logic [CNT_W-1:0] o_flag_cnt;
  logic [CNT_W-1:0] o_drop_cnt;

  sync_arith_result_collector #(.BITS(BITS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_result(i_result),
    .i_status(i_status), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_data_status(o_data_status), .o_full(o_full), .o_empty(o_empty),
    .o_count(o_count), .i_clr(i_clr), .i_cnt_sel(i_cnt_sel),
    .o_flag_cnt(o_flag_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a plain queue of accepted entries plus integer statistics.
  logic [BITS-1:0] rq [$];
  logic [3:0]      sq [$];
  int              fc [4];
  int              drops;
  int              n_checks = 0;
  int              n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    rq.delete();
    sq.delete();
    for (int i = 0; i < 4; i++) fc[i] = 0;
    drops = 0;
  endtask

  // Compares every output against the model; sweeps the counter select within the cycle.
  task automatic check_all(input string tag);
    int n;
    n = rq.size();
    check({tag, ".count"}, 64'(o_count), 64'(n));
    check({tag, ".valid"}, 64'(o_valid), 64'(n > 0));
    check({tag, ".empty"}, 64'(o_empty), 64'(n == 0));
    check({tag, ".full"},  64'(o_full),  64'(n == DEPTH));
    check({tag, ".data"},  64'(o_data),  (n > 0) ? 64'(rq[0]) : 64'd0);
    check({tag, ".dstat"}, 64'(o_data_status), (n > 0) ? 64'(sq[0]) : 64'd0);
    check({tag, ".drop"},  64'(o_drop_cnt), 64'(drops));
    for (int s = 0; s < 4; s++) begin
      i_cnt_sel = 2'(s);
      #1;
      check({tag, $sformatf(".flag%0d", s)}, 64'(o_flag_cnt), 64'(fc[s]));
    end
  endtask

  // Advance one clock: the model consumes the same inputs the DUT samples at the edge.
  task automatic step(input string tag);
    bit full_m, pop_m, push_m;
    full_m = (rq.size() == DEPTH);
    pop_m  = (rq.size() > 0) && i_ready;
    push_m = i_valid && (!full_m || pop_m);
    if (i_clr) begin
      for (int i = 0; i < 4; i++) fc[i] = 0;
      drops = 0;
    end else begin
      if (push_m)
        for (int i = 0; i < 4; i++) if (i_status[i] && fc[i] < MAXC) fc[i]++;
      if (i_valid && !push_m && drops < MAXC) drops++;
    end
    if (pop_m) begin
      void'(rq.pop_front());
      void'(sq.pop_front());
    end
    if (push_m) begin
      rq.push_back(i_result);
      sq.push_back(i_status);
    end
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [BITS-1:0] r, input logic [3:0] s,
                       input bit rdy, input bit clr);
    i_valid  = v;
    i_result = r;
    i_status = s;
    i_ready  = rdy;
    i_clr    = clr;
  endtask

  initial begin
    i_reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    i_cnt_sel = 2'd0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check_all("reset");
    step("idle");

    // Fill with consumer stalled.
    drive(1, 32'h11111111, 4'b0001, 0, 0); step("fill1");
    drive(1, 32'h22222222, 4'b0011, 0, 0); step("fill2");
    drive(1, 32'h33333333, 4'b0101, 0, 0); step("fill3");
    drive(1, 32'h44444444, 4'b1001, 0, 0); step("fill4");
    check("fill.full_direct", 64'(o_full), 64'd1);
    i_cnt_sel = 2'd0; #1;
    check("fill.flag0_direct", 64'(o_flag_cnt), 64'd4);

    drive(1, 32'h55555555, 4'b1111, 0, 0); step("drop");
    check("drop.cnt_direct", 64'(o_drop_cnt), 64'd1);

    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_head%0d", k), 64'(o_data), 64'(32'h11111111 * (k + 1)));
      drive(0, '0, '0, 1, 0);
      step("drain");
    end
    check("drain.empty_direct", 64'(o_empty), 64'd1);

    // Refill, then stream through a full FIFO across pointer wrap.
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h100 + 32'(k), 4'(k), 0, 0);
      step("refill");
    end
    for (int k = 0; k < 8; k++) begin
      drive(1, 32'h200 + 32'(k), 4'(k), 1, 0);
      step("stream");
    end
    check("stream.nodrop", 64'(o_drop_cnt), 64'd1);
    drive(0, '0, '0, 1, 0);
    repeat (5) step("flush");

    // Single entry into empty FIFO with consumer ready.
    check("bypass.before", 64'(o_valid), 64'd0);
    drive(1, 32'hDEADBEEF, 4'b0010, 1, 0); step("dbe_push");
    check("dbe.data_direct", 64'(o_data), 64'hDEADBEEF);
    drive(0, '0, '0, 1, 0); step("dbe_pop");
    check("dbe.gone", 64'(o_valid), 64'd0);

    // Saturate counters, then clear alongside a push.
    for (int k = 0; k < 300; k++) begin
      drive(1, 32'(k), 4'b1111, 1, 0);
      step("sat");
    end
    i_cnt_sel = 2'd3; #1;
    check("sat.flag3_direct", 64'(o_flag_cnt), 64'(MAXC));
    drive(1, 32'hABCD, 4'b1111, 1, 1); step("clr");
    drive(0, '0, '0, 1, 0); repeat (2) step("post_clr");

    // Asynchronous reset with three entries stored.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h300 + 32'(k), 4'b0100, 0, 0);
      step("pre_rst");
    end
    drive(0, '0, '0, 0, 0);
    #2;
    i_reset = 1'b1;
    #1;
    check("async_rst.count", 64'(o_count), 64'd0);
    check("async_rst.valid", 64'(o_valid), 64'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check_all("after_rst");
    drive(1, 32'hCAFE0001, 4'b1000, 0, 0); step("first_after_rst");
    check("first_after_rst.data", 64'(o_data), 64'hCAFE0001);
    drive(0, '0, '0, 1, 0); step("first_after_rst_pop");

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_arith_result_collector.md
Name: sync_arith_result_collector

Overview:
- Downstream stage of the synchronous arithmetic unit: captures each registered result/status pair and buffers it in a FIFO.
- Hands entries to a consumer over a valid/ready interface.
- Keeps per-status-bit event counters and a drop counter, so result bursts and flag statistics survive consumer back-pressure.
- Sits between the ALU outputs (o_result/o_status) and the bus/host logic that reads results.

Parameters:
- BITS, 32, width of result data (matches the ALU BITS).
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- CNT_W, 8, width of each flag counter and of the drop counter.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  ALU result/status valid this cycle
- i_result  in  BITS  ALU result
- i_status  in  4  ALU status flags
- o_valid  out  1  FIFO head entry available
- i_ready  in  1  consumer accepts head entry
- o_data  out  BITS  head entry result
- o_data_status  out  4  head entry status
- o_full  out  1  FIFO holds DEPTH entries
- o_empty  out  1  FIFO holds 0 entries
- o_count  out  $clog2(DEPTH)+1  current occupancy
- i_clr  in  1  synchronous clear of flag and drop counters
- i_cnt_sel  in  2  selects which flag counter drives o_flag_cnt
- o_flag_cnt  out  CNT_W  count of accepted entries with i_status[i_cnt_sel]=1
- o_drop_cnt  out  CNT_W  count of entries discarded due to full

Behaviour:
- Reset (async, active-high), applied immediately regardless of clock:
  - pointers 0, o_count 0, o_empty 1, o_full 0, o_valid 0
  - o_data 0, o_data_status 0
  - all four flag counters 0, o_drop_cnt 0
  - memory contents need not be reset.
- Reset asserted mid-burst discards all stored entries; the first push after reset release is the first entry out.
- push = i_valid && (!o_full || pop).
- pop = o_valid && i_ready.
- Output is first-word-fall-through:
  - o_valid = !o_empty.
  - o_data/o_data_status show the head entry combinationally from registered state.
  - o_data/o_data_status are forced to 0 while empty.
- Latency: an entry pushed at edge N is visible on o_data with o_valid=1 after edge N; no same-cycle bypass from i_result to o_data.
- Simultaneous push and pop:
  - Occupancy unchanged; both pointers advance.
  - Allowed when full: the write succeeds because the pop frees a slot.
  - Allowed when empty only if o_valid=0, so pop=0 and the case reduces to push only.
- Drop: i_valid=1 && o_full=1 && pop=0 → entry discarded, FIFO unchanged, o_drop_cnt += 1.
- Pointers wrap modulo DEPTH. Full/empty are derived from a count register or an extra pointer bit, never from pointer equality alone.
- o_count changes by +1 (push only), -1 (pop only) or 0, and is in [0, DEPTH].
- Flag counters: on each push, counter i increments if i_status[i]=1, for i=0..3 in parallel. Dropped entries are not counted.
- Counter rules:
  - All counters saturate at 2^CNT_W-1 and do not wrap.
  - i_clr=1 zeroes all flag counters and o_drop_cnt at the next edge; clear wins over a same-cycle increment.
  - i_clr does not affect FIFO contents or pointers.
- o_flag_cnt = counter[i_cnt_sel], combinational mux of registered counters.
- i_ready while o_valid=0 is ignored; i_valid=0 never writes.

Test Plan:
- Reset then idle → o_empty=1, o_valid=0, o_data=0, o_count=0, all counters 0; assert i_reset mid-stream with 3 entries stored → o_count=0 and o_valid=0 immediately, before any clock edge.
- i_ready=0, push 0x11111111/st 4'b0001, 0x22222222/4'b0011, 0x33333333/4'b0101, 0x44444444/4'b1001 → o_full=1, o_count=4; flag counts [0]=4, [1]=1, [2]=1, [3]=1.
- Still full, push 0x55555555 with i_ready=0 → o_drop_cnt=1, o_count=4; then i_ready=1 for 4 cycles → o_data sequence 0x11111111..0x44444444, then o_empty=1.
- Full FIFO with i_valid=1 and i_ready=1 for 8 cycles on incrementing data → o_count stays 4, no drops, output order strictly FIFO across pointer wrap.
- Empty FIFO, push 0xDEADBEEF at edge N with i_ready=1 → o_valid=0 before N, o_valid=1 and o_data=0xDEADBEEF after N, popped at N+1.
- CNT_W=8: 300 pushes with i_status=4'b1111 and i_ready=1 → all flag counters saturate at 255; i_clr=1 in the same cycle as a push → counters read 0 next cycle.
